// File: rtl/ddr2_wm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_wm_pkg
//  Description : Shared FSM encoding and constants for the DDR2 frame write
//                master and its burst calculator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr2_wm_pkg;

  // Width of the controller's local_size field (bursts of 1..7 beats).
  localparam int LOCAL_SIZE_W = 3;

  // Byte-enable pattern; wide enough for any supported data width, sliced
  // down to DATA_W/8 at the point of use.
  localparam logic [255:0] BE_ALL_ONES = '1;

  // Write-master FSM encoding.
  localparam int           STATE_W      = 2;
  localparam logic [1:0]   ST_IDLE      = 2'd0;
  localparam logic [1:0]   ST_WAIT_DATA = 2'd1;
  localparam logic [1:0]   ST_BURST     = 2'd2;
  localparam logic [1:0]   ST_DONE      = 2'd3;

endpackage : ddr2_wm_pkg
`default_nettype wire

// File: rtl/ddr2_wm_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_wm_burst_calc
//  Description : Combinational burst sizing for the frame write master:
//                size = min(BURST_LEN, remaining), the FIFO-level check that
//                guarantees a burst never stalls for data, and the address
//                advance applied at the end of a burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr2_wm_burst_calc
  import ddr2_wm_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int CNT_W     = 20,
  parameter int BURST_LEN = 4
) (
  input  logic [CNT_W-1:0]        remaining,
  input  logic [CNT_W-1:0]        usedw,
  input  logic [ADDR_W-1:0]       cur_addr,
  input  logic [LOCAL_SIZE_W-1:0] held_size,
  output logic [LOCAL_SIZE_W-1:0] size,
  output logic                    data_ok,
  output logic [ADDR_W-1:0]       next_addr
);

  localparam logic [CNT_W-1:0]        BURST_LEN_CNT = CNT_W'(BURST_LEN);
  localparam logic [LOCAL_SIZE_W-1:0] BURST_LEN_SZ  = LOCAL_SIZE_W'(BURST_LEN);

  // Burst size and "enough words buffered" decision for the next burst.
  always_comb begin
    size = BURST_LEN_SZ;
    if (remaining < BURST_LEN_CNT) begin
      size = remaining[LOCAL_SIZE_W-1:0];
    end
    data_ok = (usedw >= {{(CNT_W-LOCAL_SIZE_W){1'b0}}, size});
  end

  // Next burst start; the add is ADDR_W wide so it wraps naturally.
  always_comb begin
    next_addr = cur_addr + {{(ADDR_W-LOCAL_SIZE_W){1'b0}}, held_size};
  end

endmodule : ddr2_wm_burst_calc
`default_nettype wire

// File: rtl/ddr2_frame_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : ddr2_frame_write_master
//  Description : Drains 256-bit words from a show-ahead pixel FIFO and writes
//                one frame to DDR2 through the controller local port as a
//                sequence of write bursts starting at a programmable base.
//                Optional macro FRAME_DBUF_EN adds ping-pong frame buffers
//                (frame_base_b input, active_buf output).
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr2_frame_write_master
  import ddr2_wm_pkg::*;
#(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 256,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 20
) (
  input  logic                    phy_clk,
  input  logic                    reset_phy_clk_n,
  input  logic                    local_init_done,
  input  logic                    local_ready,
  output logic [ADDR_W-1:0]       local_address,
  output logic                    local_write_req,
  output logic                    local_burstbegin,
  output logic [LOCAL_SIZE_W-1:0] local_size,
  output logic [DATA_W-1:0]       local_wdata,
  output logic [DATA_W/8-1:0]     local_be,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [CNT_W-1:0]        in_usedw,
  output logic                    in_rdreq,
  input  logic                    frame_start,
  input  logic [ADDR_W-1:0]       frame_base,
  input  logic [CNT_W-1:0]        frame_words,
`ifdef FRAME_DBUF_EN
  input  logic [ADDR_W-1:0]       frame_base_b,
  output logic                    active_buf,
`endif
  output logic                    busy,
  output logic                    frame_done
);

  logic [STATE_W-1:0]      state;
  logic [ADDR_W-1:0]       cur_addr;
  logic [CNT_W-1:0]        remaining;
  logic [LOCAL_SIZE_W-1:0] beat_cnt;

  logic [LOCAL_SIZE_W-1:0] calc_size;
  logic                    calc_data_ok;
  logic [ADDR_W-1:0]       calc_next_addr;

  logic                    accept;
  logic                    last_beat;
  logic                    last_burst;
  logic [ADDR_W-1:0]       start_base;
  logic [CNT_W-1:0]        start_words;

  ddr2_wm_burst_calc #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .BURST_LEN (BURST_LEN)
  ) u_burst_calc (
    .remaining (remaining),
    .usedw     (in_usedw),
    .cur_addr  (cur_addr),
    .held_size (local_size),
    .size      (calc_size),
    .data_ok   (calc_data_ok),
    .next_addr (calc_next_addr)
  );

  // Output decode from state; registered state keeps these glitch-free and
  // forces them low as soon as reset asserts.
  always_comb begin
    local_write_req = (state == ST_BURST);
    busy            = (state == ST_WAIT_DATA) || (state == ST_BURST);
    frame_done      = (state == ST_DONE);
    accept          = local_write_req && local_ready;
    in_rdreq        = accept;
    local_wdata     = in_data;
    local_be        = BE_ALL_ONES[DATA_W/8-1:0];
    last_beat       = (beat_cnt == (local_size - 3'd1));
    last_burst      = (remaining == {{(CNT_W-LOCAL_SIZE_W){1'b0}}, local_size});
  end

  // Frame parameters captured on start; a zero word count becomes one word.
  always_comb begin
    start_words = frame_words;
    if (frame_words == '0) begin
      start_words = {{(CNT_W-1){1'b0}}, 1'b1};
    end
`ifdef FRAME_DBUF_EN
    // active_buf names the last completed buffer, so write the other one.
    start_base = active_buf ? frame_base : frame_base_b;
`else
    start_base = frame_base;
`endif
  end

  // Main FSM: start capture, data-wait, burst beats and end-of-frame pulse.
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      state            <= ST_IDLE;
      cur_addr         <= '0;
      remaining        <= '0;
      beat_cnt         <= '0;
      local_address    <= '0;
      local_size       <= '0;
      local_burstbegin <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start && local_init_done) begin
            cur_addr  <= start_base;
            remaining <= start_words;
            state     <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (calc_data_ok) begin
            local_size       <= calc_size;
            local_address    <= cur_addr;
            local_burstbegin <= 1'b1;
            beat_cnt         <= '0;
            state            <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (accept) begin
            local_burstbegin <= 1'b0;
            beat_cnt         <= beat_cnt + 3'd1;
            if (last_beat) begin
              cur_addr  <= calc_next_addr;
              remaining <= remaining - {{(CNT_W-LOCAL_SIZE_W){1'b0}}, local_size};
              state     <= last_burst ? ST_DONE : ST_WAIT_DATA;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FRAME_DBUF_EN
  // Ping-pong buffer flag; flips as each frame completes.
  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      active_buf <= 1'b1;
    end else if (state == ST_DONE) begin
      active_buf <= ~active_buf;
    end
  end
`endif

endmodule : ddr2_frame_write_master
`default_nettype wire

// File: tb/tb_ddr2_frame_write_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr2_frame_write_master
//  Description : Directed self-checking bench for ddr2_frame_write_master.
//                Build with FRAME_DBUF_EN defined to cover ping-pong buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr2_frame_write_master;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;
  localparam int CNT_W  = 20;

  logic              phy_clk = 1'b0;
  logic              reset_phy_clk_n;
  logic              local_init_done;
  logic              local_ready;
  logic [ADDR_W-1:0] local_address;
  logic              local_write_req;
  logic              local_burstbegin;
  logic [2:0]        local_size;
  logic [DATA_W-1:0] local_wdata;
  logic [DATA_W/8-1:0] local_be;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_usedw;
  logic              in_rdreq;
  logic              frame_start;
  logic [ADDR_W-1:0] frame_base;
  logic [CNT_W-1:0]  frame_words;
  logic              busy;
  logic              frame_done;
`ifdef FRAME_DBUF_EN
  logic [ADDR_W-1:0] frame_base_b;
  logic              active_buf;
`endif

  ddr2_frame_write_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(4), .CNT_W(CNT_W)
  ) dut (
    .phy_clk          (phy_clk),
    .reset_phy_clk_n  (reset_phy_clk_n),
    .local_init_done  (local_init_done),
    .local_ready      (local_ready),
    .local_address    (local_address),
    .local_write_req  (local_write_req),
    .local_burstbegin (local_burstbegin),
    .local_size       (local_size),
    .local_wdata      (local_wdata),
    .local_be         (local_be),
    .in_data          (in_data),
    .in_usedw         (in_usedw),
    .in_rdreq         (in_rdreq),
    .frame_start      (frame_start),
    .frame_base       (frame_base),
    .frame_words      (frame_words),
`ifdef FRAME_DBUF_EN
    .frame_base_b     (frame_base_b),
    .active_buf       (active_buf),
`endif
    .busy             (busy),
    .frame_done       (frame_done)
  );

  always #5 phy_clk = ~phy_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: samples on the falling edge, midway between active edges.
  int pops = 0, beats = 0, dones = 0, nbursts = 0, beats_at_done = 0;
  logic [ADDR_W-1:0] b_addr [64];
  logic [2:0]        b_size [64];

  always @(negedge phy_clk) begin
    if (reset_phy_clk_n) begin
      if (in_rdreq) pops++;
      if (local_write_req && local_ready) begin
        beats++;
        if (local_burstbegin) begin
          if (nbursts < 64) begin
            b_addr[nbursts] = local_address;
            b_size[nbursts] = local_size;
          end
          nbursts++;
        end
      end
      if (frame_done) begin
        dones++;
        beats_at_done = beats;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge phy_clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] base_b,
                             input logic [CNT_W-1:0] words);
    @(posedge phy_clk);
    #1;
    frame_base  = base;
    frame_words = words;
`ifdef FRAME_DBUF_EN
    frame_base_b = base_b;
`else
    if (base_b != base) frame_base = base;
`endif
    frame_start = 1'b1;
    @(posedge phy_clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge phy_clk);
      #1;
      if (dones != d0) begin
        ok = 1'b1;
        break;
      end
    end
    check_val(tag, 64'(ok), 64'd1);
  endtask

  task automatic wait_req(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (local_write_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge phy_clk);
      #1;
    end
    check_val(tag, 64'(ok), 64'd1);
  endtask

  int p0, b0, d0, n0;
  bit ready_pat [6];

  task automatic snap();
    p0 = pops; b0 = beats; d0 = dones; n0 = nbursts;
  endtask

  initial begin
    reset_phy_clk_n = 1'b0;
    local_init_done = 1'b1;
    local_ready     = 1'b1;
    in_data         = {8{32'hA5A5_0000}};
    in_usedw        = 20'd8;
    frame_start     = 1'b0;
    frame_base      = '0;
    frame_words     = '0;
`ifdef FRAME_DBUF_EN
    frame_base_b    = '0;
`endif
    tick(3);

    // Reset state
    check_val("rst_write_req", 64'(local_write_req), 64'd0);
    check_val("rst_burstbegin", 64'(local_burstbegin), 64'd0);
    check_val("rst_address", 64'(local_address), 64'd0);
    check_val("rst_size", 64'(local_size), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_rdreq", 64'(in_rdreq), 64'd0);
    check_val("rst_be", 64'(local_be), 64'hFFFF_FFFF);
    reset_phy_clk_n = 1'b1;
    tick(2);

    // 1: eight words, two full bursts
    snap();
    start_frame(25'h100, 25'h100, 20'd8);
    check_val("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done_wait", d0, 50);
    tick(3);
    check_val("t1_bursts", 64'(nbursts - n0), 64'd2);
    check_val("t1_addr0", 64'(b_addr[n0]), 64'h100);
    check_val("t1_addr1", 64'(b_addr[n0+1]), 64'h104);
    check_val("t1_size0", 64'(b_size[n0]), 64'd4);
    check_val("t1_size1", 64'(b_size[n0+1]), 64'd4);
    check_val("t1_pops", 64'(pops - p0), 64'd8);
    check_val("t1_dones", 64'(dones - d0), 64'd1);
    check_val("t1_busy_end", 64'(busy), 64'd0);

    // 2: six words, short final burst
    snap();
    start_frame(25'h200, 25'h200, 20'd6);
    wait_done("t2_done_wait", d0, 50);
    tick(3);
    check_val("t2_bursts", 64'(nbursts - n0), 64'd2);
    check_val("t2_addr0", 64'(b_addr[n0]), 64'h200);
    check_val("t2_addr1", 64'(b_addr[n0+1]), 64'h204);
    check_val("t2_size0", 64'(b_size[n0]), 64'd4);
    check_val("t2_size1", 64'(b_size[n0+1]), 64'd2);
    check_val("t2_beats_at_done", 64'(beats_at_done - b0), 64'd6);
    check_val("t2_pops", 64'(pops - p0), 64'd6);

    // 3: ready stalls mid-burst
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    local_ready = 1'b0;
    snap();
    start_frame(25'h300, 25'h300, 20'd4);
    wait_req("t3_req_wait", 10);
    for (int i = 0; i < 6; i++) begin
      local_ready = ready_pat[i];
      #1;
      if (!ready_pat[i]) begin
        check_val("t3_stall_req", 64'(local_write_req), 64'd1);
        check_val("t3_stall_rdreq", 64'(in_rdreq), 64'd0);
        check_val("t3_stall_bb", 64'(local_burstbegin), 64'd0);
        check_val("t3_stall_addr", 64'(local_address), 64'h300);
        check_val("t3_stall_size", 64'(local_size), 64'd4);
      end
      @(posedge phy_clk);
      #1;
    end
    local_ready = 1'b1;
    wait_done("t3_done_wait", d0, 20);
    tick(2);
    check_val("t3_pops", 64'(pops - p0), 64'd4);
    check_val("t3_bursts", 64'(nbursts - n0), 64'd1);

    // 4: FIFO level one short of the burst size holds off the request
    in_usedw = 20'd3;
    snap();
    start_frame(25'h400, 25'h400, 20'd4);
    tick(5);
    check_val("t4_no_req", 64'(local_write_req), 64'd0);
    check_val("t4_busy", 64'(busy), 64'd1);
    in_usedw = 20'd4;
    #1;
    check_val("t4_no_req_yet", 64'(local_write_req), 64'd0);
    tick(1);
    check_val("t4_req_next", 64'(local_write_req), 64'd1);
    check_val("t4_bb", 64'(local_burstbegin), 64'd1);
    wait_done("t4_done_wait", d0, 20);
    in_usedw = 20'd8;
    tick(2);
    check_val("t4_pops", 64'(pops - p0), 64'd4);

    // 5a: start without calibration is dropped
    local_init_done = 1'b0;
    snap();
    start_frame(25'h500, 25'h500, 20'd4);
    tick(3);
    check_val("t5_noinit_busy", 64'(busy), 64'd0);
    local_init_done = 1'b1;
    tick(4);
    check_val("t5_noinit_still_idle", 64'(busy), 64'd0);
    check_val("t5_noinit_bursts", 64'(nbursts - n0), 64'd0);

    // 5b: start while busy ignored, address wraps
    in_usedw = 20'd0;
    snap();
    start_frame(25'h1FF_FFFE, 25'h1FF_FFFE, 20'd8);
    tick(2);
    start_frame(25'h50, 25'h50, 20'd1);
    in_usedw = 20'd8;
    wait_done("t5_done_wait", d0, 50);
    tick(4);
    check_val("t5_bursts", 64'(nbursts - n0), 64'd2);
    check_val("t5_addr0", 64'(b_addr[n0]), 64'h1FF_FFFE);
    check_val("t5_addr_wrap", 64'(b_addr[n0+1]), 64'h000_0002);
    check_val("t5_dones", 64'(dones - d0), 64'd1);
    check_val("t5_idle_after", 64'(busy), 64'd0);

    // zero-word frame behaves as a single word
    snap();
    start_frame(25'h600, 25'h600, 20'd0);
    wait_done("t0w_done_wait", d0, 20);
    tick(2);
    check_val("t0w_size", 64'(b_size[n0]), 64'd1);
    check_val("t0w_pops", 64'(pops - p0), 64'd1);

    // Reset mid-burst clears outputs immediately
    local_ready = 1'b0;
    start_frame(25'h700, 25'h700, 20'd4);
    wait_req("trst_req_wait", 10);
    local_ready = 1'b1;
    reset_phy_clk_n = 1'b0;
    #1;
    check_val("trst_write_req", 64'(local_write_req), 64'd0);
    check_val("trst_bb", 64'(local_burstbegin), 64'd0);
    check_val("trst_addr", 64'(local_address), 64'd0);
    check_val("trst_size", 64'(local_size), 64'd0);
    check_val("trst_rdreq", 64'(in_rdreq), 64'd0);
    check_val("trst_busy", 64'(busy), 64'd0);
    tick(2);
    reset_phy_clk_n = 1'b1;
    tick(2);

`ifdef FRAME_DBUF_EN
    // 6: ping-pong buffers
    check_val("t6_active_rst", 64'(active_buf), 64'd1);
    snap();
    start_frame(25'h0, 25'h8_0000, 20'd4);
    wait_done("t6_done_wait_a", d0, 20);
    tick(2);
    check_val("t6_addr_a", 64'(b_addr[n0]), 64'h0);
    check_val("t6_active_a", 64'(active_buf), 64'd0);
    snap();
    start_frame(25'h0, 25'h8_0000, 20'd4);
    wait_done("t6_done_wait_b", d0, 20);
    tick(2);
    check_val("t6_addr_b", 64'(b_addr[n0]), 64'h8_0000);
    check_val("t6_active_b", 64'(active_buf), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ddr2_frame_write_master
`default_nettype wire
